// File: rtl/alu_issue_sequencer.sv
// ============================================================================
// Module   : alu_issue_sequencer
// Purpose  : Issues register-file operands to an external 4-bit combinational ALU
//            and writes its result back. It also offers each result on a
//            valid/ready port.
// Options  : ALU_ISSUE_RETIRE_CNT_EN adds the retire_cnt and op_busy outputs.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_issue_sequencer #(
  parameter int NREG = 4,
  parameter int DW   = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [9:0]    instr,
  output logic [DW-1:0] alu_rs,
  output logic [DW-1:0] alu_rt,
  output logic [2:0]    alu_sel,
  input  logic [DW-1:0] alu_rd,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [1:0]    out_dst,
  input  logic [1:0]    dbg_addr,
`ifdef ALU_ISSUE_RETIRE_CNT_EN
  output logic [7:0]    retire_cnt,
  output logic          op_busy,
`endif
  output logic [DW-1:0] dbg_data
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WB    = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [DW-1:0] rf_q [NREG];
  logic [DW-1:0] alu_rs_q, alu_rt_q, out_data_q;
  logic [2:0]    alu_sel_q;
  logic [1:0]    dst_q, out_dst_q;
  logic          out_valid_q;
  logic          accept;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (in_valid) state_d = instr[9] ? S_WB : S_ISSUE;
      S_ISSUE: state_d = S_WB;
      S_WB:    if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state_q == S_IDLE);
    accept   = in_ready && in_valid;
  end

  // Operands are sampled at accept, so a dst==src write-back never feeds its own read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
      alu_rs_q    <= '0;
      alu_rt_q    <= '0;
      alu_sel_q   <= 3'b000;
      dst_q       <= 2'd0;
      out_data_q  <= '0;
      out_dst_q   <= 2'd0;
      out_valid_q <= 1'b0;
    end else begin
      if (accept) begin
        dst_q <= instr[5:4];
        if (instr[9]) begin
          rf_q[instr[5:4]] <= instr[3:0];
          out_data_q       <= instr[3:0];
          out_dst_q        <= instr[5:4];
          out_valid_q      <= 1'b1;
        end else begin
          alu_rs_q  <= rf_q[instr[3:2]];
          alu_rt_q  <= rf_q[instr[1:0]];
          alu_sel_q <= instr[8:6];
        end
      end
      if (state_q == S_ISSUE) begin
        rf_q[dst_q] <= alu_rd;
        out_data_q  <= alu_rd;
        out_dst_q   <= dst_q;
        out_valid_q <= 1'b1;
      end
      if (state_q == S_WB && out_ready) out_valid_q <= 1'b0;
    end
  end

  assign alu_rs    = alu_rs_q;
  assign alu_rt    = alu_rt_q;
  assign alu_sel   = alu_sel_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_dst   = out_dst_q;
  assign dbg_data  = rf_q[dbg_addr];

`ifdef ALU_ISSUE_RETIRE_CNT_EN
  logic [7:0] retire_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                           retire_cnt_q <= 8'd0;
    else if (out_valid_q && out_ready) retire_cnt_q <= retire_cnt_q + 8'd1;
  end

  assign retire_cnt = retire_cnt_q;
  assign op_busy    = (state_q != S_IDLE);
`endif

endmodule

`default_nettype wire

// File: tb/tb_alu_issue_sequencer.sv
// ============================================================================
// Module   : tb_alu_issue_sequencer
// Purpose  : Randomized self-checking bench for alu_issue_sequencer. The bench
//            acts as the external ALU and keeps an architectural register model.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_alu_issue_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_ready;
  logic [9:0] instr;
  logic [3:0] alu_rs, alu_rt, alu_rd;
  logic [2:0] alu_sel;
  logic       out_valid, out_ready;
  logic [3:0] out_data;
  logic [1:0] out_dst;
  logic [1:0] dbg_addr;
  logic [3:0] dbg_data;
`ifdef ALU_ISSUE_RETIRE_CNT_EN
  logic [7:0] retire_cnt;
  logic       op_busy;
  int         exp_cnt = 0;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  logic [3:0] ref_rf [4];

  always #5 clk = ~clk;

  alu_issue_sequencer dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
    .alu_rs(alu_rs), .alu_rt(alu_rt), .alu_sel(alu_sel), .alu_rd(alu_rd),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_dst(out_dst),
    .dbg_addr(dbg_addr),
`ifdef ALU_ISSUE_RETIRE_CNT_EN
    .retire_cnt(retire_cnt), .op_busy(op_busy),
`endif
    .dbg_data(dbg_data)
  );

  // Reference ALU semantics, also used to drive alu_rd.
  function automatic logic [3:0] alu_func(input logic [2:0] op,
                                          input logic [3:0] a, input logic [3:0] b);
    int s;
    case (op)
      3'd0: s = (int'(a) + int'(b)) % 16;
      3'd1: s = (int'(a) - int'(b) + 16) % 16;
      3'd2: s = int'(a & b);
      3'd3: s = int'(a | b);
      3'd4: s = (int'(a) * 2) % 16 + int'(a) / 8;
      3'd5: s = int'(b) / 2 + ((b >= 4'd8) ? 8 : 0);
      3'd6: s = (a == b) ? 15 : 14;
      default: s = (a > b) ? 11 : 10;
    endcase
    return s[3:0];
  endfunction

  always_comb alu_rd = alu_func(alu_sel, alu_rs, alu_rt);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) ref_rf[i] = 4'h0;
  endtask

  // Issue one instruction and walk it through accept, optional ISSUE, and WB.
  task automatic run_instr(input logic [9:0] ins, input int hold);
    logic [3:0] exp, exp_rs, exp_rt;
    logic [1:0] dst;
    dst    = ins[5:4];
    exp_rs = ref_rf[ins[3:2]];
    exp_rt = ref_rf[ins[1:0]];
    exp    = ins[9] ? ins[3:0] : alu_func(ins[8:6], exp_rs, exp_rt);
    check("in_ready_idle", in_ready, 1);
    in_valid  = 1'b1;
    instr     = ins;
    out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    if (!ins[9]) begin
      check("issue_sel", alu_sel, ins[8:6]);
      check("issue_rs", alu_rs, exp_rs);
      check("issue_rt", alu_rt, exp_rt);
      check("issue_no_valid", out_valid, 0);
      @(negedge clk);
    end
    ref_rf[dst] = exp;
    check("wb_valid", out_valid, 1);
    check("wb_data", out_data, exp);
    check("wb_dst", out_dst, dst);
    check("wb_in_ready", in_ready, 0);
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1;
      instr    = 10'($urandom);
      @(negedge clk);
      check("hold_valid", out_valid, 1);
      check("hold_data", out_data, exp);
      check("hold_dst", out_dst, dst);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
`ifdef ALU_ISSUE_RETIRE_CNT_EN
    exp_cnt = (exp_cnt + 1) % 256;
    check("retire_cnt", retire_cnt, exp_cnt);
    check("op_busy_idle", op_busy, 0);
`endif
    check("post_valid", out_valid, 0);
    check("post_in_ready", in_ready, 1);
    dbg_addr = dst;
    #1;
    check("dbg_wb", dbg_data, exp);
  endtask

  function automatic logic [9:0] mk(input logic imm, input logic [2:0] op,
                                    input logic [1:0] d, input logic [1:0] s,
                                    input logic [1:0] t);
    return {imm, op, d, s, t};
  endfunction

  initial begin
    in_valid  = 1'b0;
    instr     = '0;
    out_ready = 1'b0;
    dbg_addr  = 2'd0;
    do_reset();

    for (int a = 0; a < 4; a++) begin
      dbg_addr = 2'(a);
      #1;
      check("reset_dbg", dbg_data, 0);
    end
    check("reset_in_ready", in_ready, 1);
    check("reset_out_valid", out_valid, 0);
    check("reset_sel", alu_sel, 0);

    // Directed values from the reference scenario.
    run_instr(mk(1, 0, 2'd1, 2'b10, 2'b01), 0);   // LI r1=9
    run_instr(mk(1, 0, 2'd2, 2'b01, 2'b01), 0);   // LI r2=5
    run_instr(mk(0, 0, 2'd3, 2'd1, 2'd2), 0);     // ADD r3 -> E
    check("add_E", ref_rf[3], 4'hE);
    run_instr(mk(0, 1, 2'd0, 2'd2, 2'd1), 1);     // SUB -> C
    run_instr(mk(0, 7, 2'd0, 2'd1, 2'd2), 0);     // GT -> B
    run_instr(mk(0, 6, 2'd0, 2'd1, 2'd1), 2);     // EQ -> F
    run_instr(mk(0, 4, 2'd0, 2'd1, 2'd1), 0);     // ROL 9 -> 3
    run_instr(mk(0, 5, 2'd0, 2'd1, 2'd1), 5);     // ASR 9 -> C, long hold
    run_instr(mk(0, 0, 2'd1, 2'd1, 2'd1), 0);     // r1=r1+r1 -> 2
    dbg_addr = 2'd1;
    #1;
    check("hazard_r1", dbg_data, 4'h2);

    for (int n = 0; n < 260; n++)
      run_instr(10'($urandom), int'($urandom_range(0, 3)));

    // Reset in the middle of an ISSUE cycle drops the instruction.
    in_valid = 1'b1;
    instr    = mk(0, 0, 2'd0, 2'd1, 2'd2);
    @(negedge clk);
    in_valid = 1'b0;
    rst      = 1'b1;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) ref_rf[i] = 4'h0;
    for (int a = 0; a < 4; a++) begin
      dbg_addr = 2'(a);
      #1;
      check("rst_dbg", dbg_data, 0);
    end
    @(negedge clk);
    check("rst_no_wb", out_valid, 0);
`ifdef ALU_ISSUE_RETIRE_CNT_EN
    exp_cnt = 0;
    check("rst_retire_cnt", retire_cnt, 0);
`endif
    run_instr(mk(1, 0, 2'd2, 2'b11, 2'b00), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

`default_nettype wire
